lc3: RTL and testbench

LC3 -- requirements
Module: lc3

---
 rtl/lc3_pkg.sv | 52 +++++
 rtl/lc3_seg_mux.sv | 42 ++++
 rtl/lc3.sv | 209 ++++++++++++++++++++
 tb/tb_lc3.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// LC3 shared definitions.
// FSM encoding, status-word layout and hex glyph table.
package lc3_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START    = 4'd1,
    S_ADDR     = 4'd2,
    S_ADDR_ACK = 4'd3,
    S_WDATA    = 4'd4,
    S_WACK     = 4'd5,
    S_RDATA    = 4'd6,
    S_RNACK    = 4'd7,
    S_STOP     = 4'd8
  } state_t;

  localparam int SDAER_OE   = 0;
  localparam int SDAER_SDA  = 1;
  localparam int SDAER_SCL  = 2;
  localparam int SDAER_BUSY = 3;
  localparam int SDAER_AERR = 4;
  localparam int SDAER_ST   = 8;
  localparam int SDAER_BC   = 12;

  localparam logic [6:0] SEG_E = 7'b0000110;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    s = 7'b1111111;
    unique case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lc3_seg_mux.sv
// LC3 four-digit seven-segment scanner.
// Shows wr_byte then rd_byte, left to right.
module lc3_seg_mux
  import lc3_pkg::*;
#(
  parameter int REFRESH_BITS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_wr_byte,
  input  logic [7:0] i_rd_byte,
  input  logic       i_err,
  output logic [6:0] o_seg,
  output logic [3:0] o_an
);

  logic [REFRESH_BITS-1:0] r_refresh;
  logic [1:0]              w_sel;
  logic [3:0]              w_nib;

  always_ff @(posedge clk) begin
    if (!rst_n) r_refresh <= '0;
    else        r_refresh <= r_refresh + 1'b1;
  end

  assign w_sel = r_refresh[REFRESH_BITS-1 -: 2];

  always_comb begin
    o_an  = 4'b1111;
    w_nib = i_rd_byte[3:0];
    unique case (w_sel)
      2'd0: begin o_an = 4'b1110; w_nib = i_rd_byte[3:0]; end
      2'd1: begin o_an = 4'b1101; w_nib = i_rd_byte[7:4]; end
      2'd2: begin o_an = 4'b1011; w_nib = i_wr_byte[3:0]; end
      2'd3: begin o_an = 4'b0111; w_nib = i_wr_byte[7:4]; end
    endcase
    o_seg = hex2seg(w_nib);
    // Leftmost digit flags a NACK
    if (w_sel == 2'd3 && i_err) o_seg = SEG_E;
  end

endmodule

// File: rtl/lc3.sv
// LC3 button-driven I2C master with hex display.
// One-byte write or read to a fixed target address.
module lc3
  import lc3_pkg::*;
#(
  parameter int         CLK_DIV      = 25,
  parameter logic [6:0] SLAVE_ADDR   = 7'h50,
  parameter int         REFRESH_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire         SDA_BUS,
  output logic        SCL_BUS,
  input  logic [7:0]  sw,
  input  logic [4:0]  btn,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [15:0] SDAER
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  state_t r_state, w_state_nxt;

  logic [DW-1:0] r_div;
  logic [1:0]    r_phase;
  logic [2:0]    r_bitcnt;
  logic [2:0]    r_btn_s1, r_btn_s2, r_btn_q;
  logic [7:0]    r_wdata, r_shift;
  logic [7:0]    r_wr_byte, r_rd_byte;
  logic          r_rw, r_nack, r_ack_err;

  logic [2:0] w_btn_rise;
  logic       w_busy, w_go, w_go_wr, w_go_rd;
  logic       w_tick, w_bit_end, w_byte_end, w_sample;
  logic       w_multi, w_sda_in;
  logic       w_scl, w_scl_bit, w_sda_oe, w_sda_out;
  logic [7:0] w_addr_byte;
  logic       w_unused;

  assign w_unused    = ^btn[4:3];
  assign w_btn_rise  = r_btn_s2 & ~r_btn_q;
  assign w_busy      = (r_state != S_IDLE);
  assign w_go_wr     = ~w_busy & w_btn_rise[0];
  assign w_go_rd     = ~w_busy & w_btn_rise[1] & ~w_btn_rise[0];
  assign w_go        = w_go_wr | w_go_rd;
  assign w_tick      = (r_div == DIV_LAST);
  assign w_bit_end   = w_tick & (r_phase == 2'd3);
  assign w_byte_end  = w_bit_end & (r_bitcnt == 3'd0);
  assign w_sample    = (r_phase == 2'd2) & (r_div == '0);
  assign w_sda_in    = SDA_BUS;
  assign w_addr_byte = {SLAVE_ADDR, r_rw};
  assign w_multi     = (r_state == S_ADDR) |
                       (r_state == S_WDATA) |
                       (r_state == S_RDATA);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_btn_q  <= '0;
    end else begin
      r_btn_s1 <= btn[2:0];
      r_btn_s2 <= r_btn_s1;
      r_btn_q  <= r_btn_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_go) w_state_nxt = S_START;
      S_START:
        if (w_tick) w_state_nxt = S_ADDR;
      S_ADDR:
        if (w_byte_end) w_state_nxt = S_ADDR_ACK;
      S_ADDR_ACK:
        if (w_bit_end)
          w_state_nxt = r_nack ? S_STOP :
                        (r_rw ? S_RDATA : S_WDATA);
      S_WDATA:
        if (w_byte_end) w_state_nxt = S_WACK;
      S_WACK:
        if (w_bit_end) w_state_nxt = S_STOP;
      S_RDATA:
        if (w_byte_end) w_state_nxt = S_RNACK;
      S_RNACK:
        if (w_bit_end) w_state_nxt = S_STOP;
      S_STOP:
        if (w_tick && r_phase == 2'd2) w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_scl     = 1'b1;
    w_sda_oe  = 1'b1;
    w_sda_out = 1'b1;
    w_scl_bit = (r_phase == 2'd1) | (r_phase == 2'd2);
    unique case (r_state)
      S_IDLE: ;
      S_START:
        w_sda_out = 1'b0;
      S_ADDR: begin
        w_scl     = w_scl_bit;
        w_sda_out = w_addr_byte[r_bitcnt];
      end
      S_ADDR_ACK, S_WACK, S_RDATA: begin
        w_scl    = w_scl_bit;
        w_sda_oe = 1'b0;
      end
      S_WDATA: begin
        w_scl     = w_scl_bit;
        w_sda_out = r_wdata[r_bitcnt];
      end
      S_RNACK:
        w_scl = w_scl_bit;
      // p0 pulls SDA low under SCL low, p1 raises SCL, p2 releases SDA
      S_STOP: begin
        w_scl     = (r_phase != 2'd0);
        w_sda_out = (r_phase == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_phase   <= '0;
      r_bitcnt  <= 3'd7;
      r_wdata   <= '0;
      r_shift   <= '0;
      r_wr_byte <= '0;
      r_rd_byte <= '0;
      r_rw      <= 1'b0;
      r_nack    <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      if (w_btn_rise[2]) r_ack_err <= 1'b0;
      if (r_state == S_IDLE) begin
        r_div    <= '0;
        r_phase  <= '0;
        r_bitcnt <= 3'd7;
        if (w_go) begin
          r_wdata   <= sw;
          r_rw      <= w_go_rd;
          r_nack    <= 1'b0;
          r_ack_err <= 1'b0;
        end
      end else begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
        if (w_tick && r_state != S_START)
          r_phase <= r_phase + 1'b1;
        if (w_bit_end)
          r_bitcnt <= (w_multi && r_bitcnt != 3'd0) ?
                      r_bitcnt - 1'b1 : 3'd7;
        if (w_sample) begin
          if (r_state == S_ADDR_ACK || r_state == S_WACK) begin
            r_nack <= w_sda_in;
            if (w_sda_in) r_ack_err <= 1'b1;
          end
          if (r_state == S_RDATA)
            r_shift <= {r_shift[6:0], w_sda_in};
        end
        if (w_bit_end && r_state == S_WACK && !r_nack)
          r_wr_byte <= r_wdata;
        if (w_byte_end && r_state == S_RDATA)
          r_rd_byte <= r_shift;
      end
    end
  end

  assign SDA_BUS = w_sda_oe ? w_sda_out : 1'bz;
  assign SCL_BUS = w_scl;

  // Bit counter field reads 0 while idle
  always_comb begin
    SDAER                     = '0;
    SDAER[SDAER_OE]           = w_sda_oe;
    SDAER[SDAER_SDA]          = w_sda_out;
    SDAER[SDAER_SCL]          = w_scl;
    SDAER[SDAER_BUSY]         = w_busy;
    SDAER[SDAER_AERR]         = r_ack_err;
    SDAER[SDAER_ST +: 4]      = r_state;
    SDAER[SDAER_BC +: 4]      = w_busy ? {1'b0, r_bitcnt} : 4'h0;
  end

  lc3_seg_mux #(
    .REFRESH_BITS (REFRESH_BITS)
  ) u_seg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_byte (r_wr_byte),
    .i_rd_byte (r_rd_byte),
    .i_err     (r_ack_err),
    .o_seg     (seg),
    .o_an      (an)
  );

endmodule

// File: tb/tb_lc3.sv
// LC3 bench: I2C slave model, bit scoreboard, display readback.
// Transactions come from a vector table; reset cases are hand-written.
module tb_lc3;

  localparam int         CLK_DIV = 4;
  localparam logic [6:0] SLAVE   = 7'h50;
  localparam int         RB      = 4;
  localparam int         BOUND   = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  wire         SDA_BUS;
  logic        SCL_BUS;
  logic [7:0]  sw = 8'h00;
  logic [4:0]  btn = 5'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] SDAER;
  logic        slave_bit = 1'b1;

  assign SDA_BUS = SDAER[0] ? 1'bz : slave_bit;

  lc3 #(
    .CLK_DIV      (CLK_DIV),
    .SLAVE_ADDR   (SLAVE),
    .REFRESH_BITS (RB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SDA_BUS (SDA_BUS),
    .SCL_BUS (SCL_BUS),
    .sw      (sw),
    .btn     (btn),
    .seg     (seg),
    .an      (an),
    .SDAER   (SDAER)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [7:0]  swv;
    logic        addr_nack;
    logic        data_nack;
    logic [7:0]  rd;
    logic [15:0] disp;
    logic        err;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  bit   timed_out = 0;
  logic exp_q[$];
  int   start_cnt = 0;
  int   stop_cnt = 0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  always @(negedge clk) begin
    if (rst_n && m_scl && SCL_BUS) begin
      if (m_sda && !SDA_BUS) start_cnt <= start_cnt + 1;
      if (!m_sda && SDA_BUS) stop_cnt <= stop_cnt + 1;
    end
    m_scl <= SCL_BUS;
    m_sda <= SDA_BUS;
  end

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40; 4'h1: return 7'h79;
      4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12;
      4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10;
      4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21;
      4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_scl(input logic lvl);
    logic prev;
    if (timed_out) return;
    prev = SCL_BUS;
    for (int n = 0; n < BOUND; n++) begin
      @(posedge clk); #1;
      if (SCL_BUS == lvl && prev != lvl) return;
      prev = SCL_BUS;
    end
    timed_out = 1;
    checks++;
    failures++;
    $display("FAIL scl_wait: no SCL edge to %0d in %0d cycles", lvl, BOUND);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 2 * BOUND; n++) begin
      @(negedge clk);
      if (!SDAER[3]) return;
    end
    checks++;
    failures++;
    $display("FAIL idle_wait: busy still %0d", SDAER[3]);
  endtask

  task automatic pop_chk(input string nm);
    logic e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got bit %0d expected none", nm, SDA_BUS);
    end else begin
      e = exp_q.pop_front();
      chk(nm, 32'(SDA_BUS), 32'(e));
      chk({nm, "_oe"}, 32'(SDAER[0]), 32'd1);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  task automatic press(input logic [4:0] m);
    @(negedge clk);
    btn = m;
    repeat (4) @(negedge clk);
    btn = 5'b0;
  endtask

  task automatic chk_display(input string nm, input logic [15:0] hx,
                             input logic err);
    logic [6:0] d [4];
    int bad;
    bad = 0;
    for (int i = 0; i < 4; i++) d[i] = 7'h7F;
    for (int n = 0; n < (1 << RB); n++) begin
      @(negedge clk);
      case (an)
        4'b1110: d[0] = seg;
        4'b1101: d[1] = seg;
        4'b1011: d[2] = seg;
        4'b0111: d[3] = seg;
        default: bad++;
      endcase
    end
    chk({nm, "_an_onehot"}, 32'(bad), 32'd0);
    chk({nm, "_dig0"}, 32'(d[0]), 32'(glyph(hx[3:0])));
    chk({nm, "_dig1"}, 32'(d[1]), 32'(glyph(hx[7:4])));
    chk({nm, "_dig2"}, 32'(d[2]), 32'(glyph(hx[11:8])));
    chk({nm, "_dig3"}, 32'(d[3]),
        32'(err ? 7'h06 : glyph(hx[15:12])));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [9];
    vec_t v;
    logic rw;
    int   st0, sp0, bad;

    tv[0] = '{2'd0, 8'hA5, 1'b0, 1'b0, 8'h00, 16'hA500, 1'b0};
    tv[1] = '{2'd1, 8'h00, 1'b0, 1'b0, 8'h3C, 16'hA53C, 1'b0};
    tv[2] = '{2'd0, 8'h12, 1'b1, 1'b0, 8'h00, 16'hA53C, 1'b1};
    tv[3] = '{2'd3, 8'h00, 1'b0, 1'b0, 8'h00, 16'hA53C, 1'b0};
    tv[4] = '{2'd0, 8'hC7, 1'b0, 1'b1, 8'h00, 16'hA53C, 1'b1};
    tv[5] = '{2'd1, 8'h00, 1'b0, 1'b0, 8'hF1, 16'hA5F1, 1'b0};
    tv[6] = '{2'd2, 8'h0E, 1'b0, 1'b0, 8'h00, 16'h0EF1, 1'b0};
    tv[7] = '{2'd1, 8'h00, 1'b1, 1'b0, 8'h99, 16'h0EF1, 1'b1};
    tv[8] = '{2'd3, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0EF1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_sdaer", 32'(SDAER), 32'h0007);
    chk("rst_an", 32'(an), 32'hE);
    chk("rst_seg", 32'(seg), 32'h40);
    rst_n = 1'b1;

    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (SCL_BUS !== 1'b1 || SDAER !== 16'h0007) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);
    chk("idle_starts", 32'(start_cnt), 32'd0);
    chk_display("disp_reset", 16'h0000, 1'b0);

    for (int k = 0; k < 9; k++) begin
      v = tv[k];
      if (v.kind == 2'd3) begin
        press(5'b00100);
        repeat (2) @(negedge clk);
      end else begin
        rw  = (v.kind == 2'd1);
        st0 = start_cnt;
        sp0 = stop_cnt;
        sw  = v.swv;
        exp_q.delete();
        push_byte({SLAVE, rw});
        if (!v.addr_nack && !rw) push_byte(v.swv);
        if (!v.addr_nack && rw) exp_q.push_back(1'b1);
        press(v.kind == 2'd0 ? 5'b00001 :
              v.kind == 2'd1 ? 5'b00010 : 5'b00011);
        sw = ~v.swv;
        for (int i = 0; i < 8; i++) begin
          wait_scl(1'b1);
          pop_chk("addr_bit");
          if (v.kind == 2'd2 && i == 3) press(5'b00001);
        end
        wait_scl(1'b0);
        slave_bit = v.addr_nack;
        wait_scl(1'b1);
        chk("addr_ack_released", 32'(SDAER[0]), 32'd0);
        if (!v.addr_nack && !rw) begin
          wait_scl(1'b0);
          slave_bit = v.data_nack;
          for (int i = 0; i < 8; i++) begin
            wait_scl(1'b1);
            pop_chk("data_bit");
          end
          wait_scl(1'b1);
          chk("data_ack_released", 32'(SDAER[0]), 32'd0);
        end else if (!v.addr_nack) begin
          for (int i = 7; i >= 0; i--) begin
            wait_scl(1'b0);
            slave_bit = v.rd[i];
            wait_scl(1'b1);
            chk("rdata_released", 32'(SDAER[0]), 32'd0);
          end
          wait_scl(1'b0);
          slave_bit = 1'b0;
          wait_scl(1'b1);
          pop_chk("master_nack");
        end
        wait_idle();
        slave_bit = 1'b1;
        repeat (50) @(negedge clk);
        chk("start_count", 32'(start_cnt - st0), 32'd1);
        chk("stop_count", 32'(stop_cnt - sp0), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
      end
      chk("sdaer_idle", 32'(SDAER), {27'b0, v.err, 4'b0111});
      chk_display("disp_vec", v.disp, v.err);
    end

    sw = 8'h5A;
    press(5'b00001);
    for (int i = 0; i < 8; i++) wait_scl(1'b1);
    wait_scl(1'b0);
    slave_bit = 1'b0;
    wait_scl(1'b1);
    wait_scl(1'b0);
    slave_bit = 1'b1;
    wait_scl(1'b1);
    chk("mid_state_wdata", 32'(SDAER[11:8]), 32'd4);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_sdaer", 32'(SDAER), 32'h0007);
    chk("midrst_scl", 32'(SCL_BUS), 32'd1);
    chk("midrst_an", 32'(an), 32'hE);
    chk("midrst_seg", 32'(seg), 32'h40);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("postrst_sdaer", 32'(SDAER), 32'h0007);
    chk_display("disp_postrst", 16'h0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
